// File: rtl/qpsk_symbol_framer.sv
// Frame builder (preamble, sync, length, payload, CRC-8) emitting 2-bit symbols; symbols update one cycle after mod_req.
// Backpressure: one-entry byte holding register, s_ready only while it is empty and bytes remain to fetch.
module qpsk_symbol_framer #(
  parameter int          PREAMBLE_SYMS = 32,
  parameter logic [15:0] SYNC_WORD     = 16'hD391
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_len,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       mod_req,
  output logic [1:0] symbol_out,
  output logic       symbol_en,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {IDLE, ARMED, PREAMBLE, SYNC, LEN, PAYLOAD, CRC} state_t;

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_SYMS - 1);

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  fetch_left, fetch_d;
  logic [7:0]  send_left, send_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full, full_d;
  logic [7:0]  crc_q, crc_d;
  logic [1:0]  sym_d;
  logic        en_d, busy_d, done_d, under_d;
  logic        hs, byte_end, need_byte;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  assign s_ready   = !hold_full && (fetch_left != 8'd0) && (state_q != IDLE) && (state_q != CRC);
  assign hs        = s_valid && s_ready;
  assign byte_end  = (cnt_q == 16'd3);
  // A new payload byte is due at the end of the length byte or of any payload byte but the last.
  assign need_byte = byte_end && (((state_q == LEN) && (len_q != 8'd0)) ||
                                  ((state_q == PAYLOAD) && (send_left != 8'd0)));

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (tx_start) state_d = ARMED;
      ARMED:    if (mod_req) state_d = PREAMBLE;
      PREAMBLE: if (mod_req && cnt_q == PRE_LAST) state_d = SYNC;
      SYNC:     if (mod_req && cnt_q == 16'd7) state_d = LEN;
      LEN, PAYLOAD:
        if (mod_req && byte_end) begin
          if (!need_byte)     state_d = CRC;
          else if (hold_full) state_d = PAYLOAD;
          else                state_d = IDLE;
        end
      CRC:      if (mod_req && byte_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d   = len_q;
    fetch_d = fetch_left;
    send_d  = send_left;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    hold_d  = hold_q;
    full_d  = hold_full;
    crc_d   = crc_q;
    sym_d   = symbol_out;
    en_d    = symbol_en;
    busy_d  = busy;
    done_d  = 1'b0;
    under_d = 1'b0;
    if (hs) begin
      hold_d  = s_data;
      full_d  = 1'b1;
      fetch_d = fetch_left - 8'd1;
    end
    case (state_q)
      IDLE:
        if (tx_start) begin
          len_d   = tx_len;
          fetch_d = tx_len;
          crc_d   = 8'h00;
          busy_d  = 1'b1;
          cnt_d   = 16'd0;
          full_d  = 1'b0;
        end
      ARMED:
        if (mod_req) begin
          sym_d = 2'b00;
          en_d  = 1'b1;
          cnt_d = 16'd0;
        end
      PREAMBLE:
        if (mod_req) begin
          if (cnt_q == PRE_LAST) begin
            sym_d   = SYNC_WORD[15:14];
            shreg_d = {SYNC_WORD[13:0], 2'b00};
            cnt_d   = 16'd0;
          end else begin
            sym_d = cnt_q[0] ? 2'b00 : 2'b10;
            cnt_d = cnt_q + 16'd1;
          end
        end
      SYNC:
        if (mod_req) begin
          if (cnt_q == 16'd7) begin
            sym_d   = len_q[7:6];
            shreg_d = {len_q[5:0], 10'd0};
            crc_d   = crc8_byte(crc_q, len_q);
            cnt_d   = 16'd0;
          end else begin
            sym_d   = shreg_q[15:14];
            shreg_d = {shreg_q[13:0], 2'b00};
            cnt_d   = cnt_q + 16'd1;
          end
        end
      LEN, PAYLOAD:
        if (mod_req) begin
          if (!byte_end) begin
            sym_d   = shreg_q[15:14];
            shreg_d = {shreg_q[13:0], 2'b00};
            cnt_d   = cnt_q + 16'd1;
          end else if (!need_byte) begin
            // CRC already includes every byte, folded as each left the holding register.
            sym_d   = crc_q[7:6];
            shreg_d = {crc_q[5:0], 10'd0};
            cnt_d   = 16'd0;
          end else if (hold_full) begin
            sym_d   = hold_q[7:6];
            shreg_d = {hold_q[5:0], 10'd0};
            crc_d   = crc8_byte(crc_q, hold_q);
            full_d  = 1'b0;
            send_d  = (state_q == LEN) ? (len_q - 8'd1) : (send_left - 8'd1);
            cnt_d   = 16'd0;
          end else begin
            sym_d   = 2'b00;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            under_d = 1'b1;
            full_d  = 1'b0;
          end
        end
      CRC:
        if (mod_req) begin
          if (byte_end) begin
            sym_d  = 2'b00;
            en_d   = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            sym_d   = shreg_q[15:14];
            shreg_d = {shreg_q[13:0], 2'b00};
            cnt_d   = cnt_q + 16'd1;
          end
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_q      <= 8'd0;
      fetch_left <= 8'd0;
      send_left  <= 8'd0;
      cnt_q      <= 16'd0;
      shreg_q    <= 16'd0;
      hold_q     <= 8'd0;
      hold_full  <= 1'b0;
      crc_q      <= 8'd0;
      symbol_out <= 2'b00;
      symbol_en  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      len_q      <= len_d;
      fetch_left <= fetch_d;
      send_left  <= send_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      hold_q     <= hold_d;
      hold_full  <= full_d;
      crc_q      <= crc_d;
      symbol_out <= sym_d;
      symbol_en  <= en_d;
      busy       <= busy_d;
      frame_done <= done_d;
      underrun   <= under_d;
    end
  end

endmodule

// File: doc/qpsk_symbol_framer.md
# qpsk_symbol_framer

Packetizing stage directly upstream of the QPSK modulator. Takes a frame length plus a stream of payload bytes and builds a complete frame: preamble, sync word, length byte, payload and CRC-8. It emits the frame as 2-bit symbols, one per modulator symbol request (`mod_req`). Its `symbol_out`/`symbol_en` drive the modulator's `symbol_in`/`symbol_en` and are held stable for the whole symbol period.

## Interface
- `PREAMBLE_SYMS`, 32: number of preamble symbols (≥2, even).
- `SYNC_WORD`, 16'hD391: sync word, sent MSB first.
- `clk` input 1: system clock; one clock domain only.
- `reset_n` input 1: synchronous, active-low reset.
- `tx_start` input 1: one-cycle frame request; accepted only while `busy`=0.
- `tx_len` input 8: payload byte count (0–255), latched with `tx_start`.
- `s_data` input 8: payload byte.
- `s_valid` input 1: `s_data` valid.
- `s_ready` output 1: framer accepts `s_data` this cycle.
- `mod_req` input 1: one-cycle symbol-boundary pulse from the modulator.
- `symbol_out` output 2: current symbol.
- `symbol_en` output 1: high while a frame symbol is being transmitted.
- `busy` output 1: frame accepted and not yet finished or aborted.
- `frame_done` output 1: one-cycle pulse when the frame completes.
- `underrun` output 1: one-cycle pulse when the frame is aborted for lack of data.

## Operation
- **States:** IDLE, ARMED, PREAMBLE, SYNC, LEN, PAYLOAD, CRC.
- **Where transitions happen:** every transition except IDLE→ARMED occurs on a clock edge where `mod_req`=1.
- **IDLE**
  - `tx_start`=1: latch `tx_len`, clear CRC to 0x00, set `busy`, go to ARMED.
  - `tx_start` while `busy`=1 is ignored.
- **ARMED:** on the next `mod_req`, load the first preamble symbol and go to PREAMBLE.
- **PREAMBLE**
  - Sends `PREAMBLE_SYMS` symbols alternating 2'b00, 2'b10, starting with 2'b00.
  - Then goes to SYNC.
- **SYNC:** 8 symbols of `SYNC_WORD`, bits [15:14] first.
- **LEN:** 4 symbols of the latched length byte.
- **PAYLOAD:** 4 symbols per byte, `tx_len` bytes. Skipped when `tx_len`=0.
- **CRC**
  - 4 symbols of the CRC-8 over the length byte and all payload bytes.
  - CRC-8 parameters: poly 0x07, init 0x00, no reflection, no final XOR.
- **Symbol bit order:** every byte is sent MSB pair first: [7:6], [5:4], [3:2], [1:0].
- **Byte holding register:** one entry, with full flag.
  - `s_ready` = !full AND bytes-still-to-fetch>0 AND state ∈ {ARMED, PREAMBLE, SYNC, LEN, PAYLOAD}.
  - A handshake (`s_valid` & `s_ready`) loads the register and sets full.
  - The byte folds into the CRC when it moves from the holding register into the symbol shift register.
- **Underrun:** a `mod_req` arrives when a new payload byte is needed and the holding register is empty.
  - Abort: `symbol_en`←0, pulse `underrun`, `busy`←0, go to IDLE.
  - Bytes not yet fetched are left untouched upstream.
- **Completion:** the `mod_req` that ends the 4th CRC symbol sets `symbol_en`←0, pulses `frame_done`, clears `busy`, and returns to IDLE.
- **Total symbols with `symbol_en`=1:** `PREAMBLE_SYMS` + 8 + 4 + 4·`tx_len` + 4.
- **Reset:** `reset_n`=0 mid-frame aborts immediately, with no `frame_done` or `underrun` pulse.

## Timing
- **Reset values:** `symbol_out`=2'b00, `symbol_en`=0, `s_ready`=0, `busy`=0, `frame_done`=0, `underrun`=0. State returns to IDLE.
- `busy` rises the cycle after `tx_start` is sampled.
- **Symbol update:** `symbol_out`/`symbol_en` are registered and change exactly one cycle after the edge on which `mod_req`=1 is sampled. They are constant between `mod_req` pulses.
- **`mod_req` and `tx_start` in the same cycle while IDLE:** that `mod_req` is not used. The frame starts on the following `mod_req`.
- `frame_done` and `underrun` are asserted in the same cycle that `symbol_en` falls.
- **Throughput:** with `s_valid` held high, the holding register refills within one cycle of being emptied, so the payload never underruns for any `mod_req` spacing ≥3 cycles.
- **Back-to-back frames:** a `tx_start` in the cycle after `frame_done` is accepted. It loses at most one symbol slot of IDLE.

## Test plan
- **len=0 frame:** `PREAMBLE_SYMS`=4, `mod_req` every 10 cycles, `tx_len`=0.
  - Required symbols: 00,10,00,10; the sync symbols 11,01,00,11,10,01,00,01; length 00,00,00,00; CRC 00,00,00,00.
  - `frame_done` pulses once, then `symbol_en`=0.
- **len=1 frame:** `tx_len`=1, payload 0x00.
  - Length symbols 00,00,00,01; payload 00,00,00,00; CRC=0x15 → 00,01,01,01.
  - 24 enabled symbols in total.
- **255-byte frame with throttling:** 255-byte random payload, `s_valid` toggled randomly but never starving.
  - Symbol stream matches the reference model.
  - Output changes exactly one cycle after each `mod_req`.
  - Exactly 255 handshakes.
- **Underrun:** `tx_len`=3; supply 2 bytes, then hold `s_valid`=0.
  - On the `mod_req` needing byte 3: `underrun` pulses, `symbol_en`=0, `busy`=0.
  - No `frame_done`.
- **`tx_start` while busy:** assert `tx_start` mid-frame with a different `tx_len`. It is ignored and the frame length is unchanged.
- **Reset mid-frame:** assert `reset_n`=0 during PAYLOAD.
  - All outputs reach their reset values on the next edge.
  - A new frame after reset is bit-exact.
